ssm_state_update_pipe: RTL and testbench

//  Fused Mamba-2 SSM state update: h_next[b,h,p,n] = dA[b,h]*h_prev[b,h,p,n] + dBx[b,h,p,n], fp16.
//  PAR-lane pipeline: fp16_mul_wrapper (M_LAT cycles) feeding fp16_add_wrapper (A_LAT cycles).

---
 rtl/ssm_state_update_pipe_if.sv | 27 ++
 rtl/ssm_state_update_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_ssm_state_update_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssm_state_update_pipe_if.sv
// Start/data/status bundle for ssm_state_update_pipe; master drives stimulus, slave is the pipe.
interface ssm_state_update_pipe_if #(
  parameter int unsigned B    = 1,
  parameter int unsigned H    = 4,
  parameter int unsigned P    = 4,
  parameter int unsigned N    = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned NSRC = 2
);
  logic [NSRC-1:0]         start;
  logic [B*H*DW-1:0]       dA_flat;
  logic [B*H*P*N*DW-1:0]   h_prev_flat;
  logic [B*H*P*N*DW-1:0]   dBx_flat;
  logic [B*H*P*N*DW-1:0]   h_next_flat;
  logic                    busy;
  logic                    done;

  modport master (
    output start, dA_flat, h_prev_flat, dBx_flat,
    input  h_next_flat, busy, done
  );

  modport slave (
    input  start, dA_flat, h_prev_flat, dBx_flat,
    output h_next_flat, busy, done
  );
endinterface

// File: rtl/ssm_state_update_pipe.sv
// Fused fp16 SSM state update h_next = dA*h_prev + dBx over PAR lanes (mul then add pipeline).
// Optional SSM_STATE_SAT_EN clamps +/-inf add results to +/-max finite.
module ssm_state_update_pipe #(
  parameter int unsigned B     = 1,
  parameter int unsigned H     = 4,
  parameter int unsigned P     = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned M_LAT = 6,
  parameter int unsigned A_LAT = 11,
  parameter int unsigned PAR   = 16,
  parameter int unsigned NSRC  = 2
) (
  input logic                    clk,
  input logic                    rst,
  ssm_state_update_pipe_if.slave bus
);
  localparam int unsigned E  = B * H * P * N;
  localparam int unsigned BH = B * H;
  localparam int unsigned IW = $clog2(E + PAR) + 1;
  localparam int unsigned CW = $clog2(PAR + 1);
  localparam int unsigned EW = (E > 1) ? $clog2(E) : 1;
  localparam int unsigned HW = (BH > 1) ? $clog2(BH) : 1;
  localparam logic [15:0] QNan = 16'h7e00;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  // Value = m * 2^ex exactly; round once to fp16 (RNE), including subnormals and overflow.
  function automatic logic [15:0] fp_round_pack(input logic s, input int ex, input logic [41:0] m);
    int lead, q, sh;
    logic [41:0] kept, low;
    logic guard, sticky;
    lead = 0; guard = 1'b0; sticky = 1'b0; kept = '0;
    for (int i = 0; i < 42; i++) if (m[i]) lead = i;
    q  = (lead + ex - 10 > -24) ? lead + ex - 10 : -24;
    sh = q - ex;
    if (sh <= 0) begin
      kept = m << (-sh);
    end else if (sh > 42) begin
      sticky = |m;
    end else begin
      kept   = m >> sh;
      low    = m >> (sh - 1);
      guard  = low[0];
      sticky = |(m & ((42'd1 << (sh - 1)) - 42'd1));
    end
    if (guard && (sticky || kept[0])) kept = kept + 42'd1;
    if (kept == 42'd2048) begin
      kept = 42'd1024;
      q    = q + 1;
    end
    if (m == '0) return {s, 15'd0};
    if (kept < 42'd1024) return {s, 5'd0, kept[9:0]};
    if (q + 25 >= 31) return {s, 5'h1f, 10'd0};
    return {s, 5'(q + 25), kept[9:0]};
  endfunction

  function automatic logic is_nan(input logic [15:0] a);
    return (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] a);
    return (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
  endfunction

  function automatic int fp_exp(input logic [15:0] a);
    return (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
  endfunction

  function automatic logic [41:0] fp_sig(input logic [15:0] a);
    return {31'd0, a[14:10] != 5'd0, a[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    s = a[15] ^ b[15];
    if (is_nan(a) || is_nan(b)) return QNan;
    if (is_inf(a) || is_inf(b))
      return ((a[14:0] == 15'd0) || (b[14:0] == 15'd0)) ? QNan : {s, 5'h1f, 10'd0};
    return fp_round_pack(s, fp_exp(a) + fp_exp(b) - 50, fp_sig(a) * fp_sig(b));
  endfunction

  // Operands are aligned to the smaller exponent so the sum is exact before rounding.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, emin;
    logic [41:0] xa, xb;
    if (is_nan(a) || is_nan(b)) return QNan;
    if (is_inf(a) && is_inf(b)) return (a[15] != b[15]) ? QNan : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    ea = fp_exp(a); eb = fp_exp(b);
    emin = (ea < eb) ? ea : eb;
    xa = fp_sig(a) << (ea - emin);
    xb = fp_sig(b) << (eb - emin);
    if (a[15] == b[15]) return fp_round_pack(a[15], emin - 25, xa + xb);
    if (xa > xb) return fp_round_pack(a[15], emin - 25, xa - xb);
    if (xb > xa) return fp_round_pack(b[15], emin - 25, xb - xa);
    return 16'h0000;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] r);
`ifdef SSM_STATE_SAT_EN
    if (r == 16'h7c00) return 16'h7bff;
    if (r == 16'hfc00) return 16'hfbff;
`endif
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [NSRC-1:0] latch_q, latch_d;
  logic [IW-1:0]   idx_q, idx_d, wcnt_q, wcnt_d;
  logic [CW-1:0]   wr_cnt;

  logic [DW-1:0] da_arr [BH];
  logic [DW-1:0] hp_arr [E];
  logic [DW-1:0] bx_arr [E];
  logic [DW-1:0] h_next_q [E];

  for (genvar g = 0; g < BH; g++) begin : g_da
    assign da_arr[g] = bus.dA_flat[g*DW +: DW];
  end
  for (genvar g = 0; g < E; g++) begin : g_elem
    assign hp_arr[g] = bus.h_prev_flat[g*DW +: DW];
    assign bx_arr[g] = bus.dBx_flat[g*DW +: DW];
    assign bus.h_next_flat[g*DW +: DW] = h_next_q[g];
  end

  logic [PAR-1:0] iss_v;
  logic [DW-1:0]  iss_p [PAR];
  logic [DW-1:0]  iss_x [PAR];
  logic [IW-1:0]  iss_t [PAR];
  logic [DW-1:0]  add_r [PAR];

  logic [PAR-1:0] mv_q [M_LAT];
  logic [DW-1:0]  mp_q [M_LAT][PAR];
  logic [DW-1:0]  mx_q [M_LAT][PAR];
  logic [IW-1:0]  mt_q [M_LAT][PAR];
  logic [PAR-1:0] av_q [A_LAT];
  logic [DW-1:0]  as_q [A_LAT][PAR];
  logic [IW-1:0]  at_q [A_LAT][PAR];

  always_comb begin
    for (int i = 0; i < PAR; i++) begin
      int unsigned li;
      li       = 32'(idx_q) + i;
      iss_v[i] = (state_q == StIssue) && (li < E);
      iss_t[i] = IW'(li);
      iss_p[i] = '0;
      iss_x[i] = '0;
      if (iss_v[i]) begin
        iss_p[i] = fp_mul(da_arr[HW'(li / (P * N))], hp_arr[EW'(li)]);
        iss_x[i] = bx_arr[EW'(li)];
      end
      add_r[i] = sat(fp_add(mp_q[M_LAT-1][i], mx_q[M_LAT-1][i]));
    end
  end

  always_comb begin
    wr_cnt = '0;
    for (int i = 0; i < PAR; i++) wr_cnt = wr_cnt + CW'(av_q[A_LAT-1][i]);
  end

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q + IW'(wr_cnt);
    unique case (state_q)
      StIdle: begin
        latch_d = latch_q | bus.start;
        if (&(latch_q | bus.start)) begin
          latch_d = '0;
          idx_d   = '0;
          wcnt_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        idx_d = idx_q + IW'(PAR);
        if (32'(idx_q) + PAR >= E) state_d = StDrain;
      end
      StDrain: if (32'(wcnt_q) >= E) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      latch_q <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      for (int s = 0; s < M_LAT; s++) mv_q[s] <= '0;
      for (int s = 0; s < A_LAT; s++) av_q[s] <= '0;
      for (int e = 0; e < E; e++) h_next_q[e] <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      mv_q[0] <= iss_v;
      for (int s = 1; s < M_LAT; s++) mv_q[s] <= mv_q[s-1];
      av_q[0] <= mv_q[M_LAT-1];
      for (int s = 1; s < A_LAT; s++) av_q[s] <= av_q[s-1];
      for (int i = 0; i < PAR; i++)
        if (av_q[A_LAT-1][i]) h_next_q[EW'(at_q[A_LAT-1][i])] <= as_q[A_LAT-1][i];
    end
  end

  // Payload stages need no reset: the valid bits above gate every write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PAR; i++) begin
      mp_q[0][i] <= iss_p[i];
      mx_q[0][i] <= iss_x[i];
      mt_q[0][i] <= iss_t[i];
      for (int s = 1; s < M_LAT; s++) begin
        mp_q[s][i] <= mp_q[s-1][i];
        mx_q[s][i] <= mx_q[s-1][i];
        mt_q[s][i] <= mt_q[s-1][i];
      end
      as_q[0][i] <= add_r[i];
      at_q[0][i] <= mt_q[M_LAT-1][i];
      for (int s = 1; s < A_LAT; s++) begin
        as_q[s][i] <= as_q[s-1][i];
        at_q[s][i] <= at_q[s-1][i];
      end
    end
  end

  assign bus.busy = (state_q == StIssue) || (state_q == StDrain);
  assign bus.done = (state_q == StDone);
endmodule

// File: tb/tb_ssm_state_update_pipe.sv
// Scoreboard bench for ssm_state_update_pipe: default build (E=64) and an N=5 build (E=80).
module tb_ssm_state_update_pipe;
  localparam int DW = 16;
  localparam int E0 = 64;
  localparam int E1 = 80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ssm_state_update_pipe_if #(.N(4)) bus0 ();
  ssm_state_update_pipe_if #(.N(5)) bus1 ();

  ssm_state_update_pipe #(.N(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ssm_state_update_pipe #(.N(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Exact conversion of small non-negative integers (< 2048) to fp16.
  function automatic logic [15:0] int_to_fp16(input int v);
    int l;
    int m;
    if (v == 0) return 16'h0000;
    l = 0;
    for (int i = 0; i < 11; i++) if (v[i]) l = i;
    m = (v << (10 - l)) & 32'h3ff;
    return {1'b0, 5'(l + 15), 10'(m)};
  endfunction

  function automatic bit fp16_nan(input logic [15:0] a);
    return (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
  endfunction

  task automatic fill0(input logic [15:0] da, input logic [15:0] hp, input logic [15:0] bx);
    for (int h = 0; h < 4; h++) bus0.dA_flat[h*DW +: DW] = da;
    for (int e = 0; e < E0; e++) begin
      bus0.h_prev_flat[e*DW +: DW] = hp;
      bus0.dBx_flat[e*DW +: DW]    = bx;
    end
  endtask

  // Pulses start on dut0 and returns cycles from the go cycle to done, or -1 on timeout.
  task automatic go_dut0(input logic [1:0] st, output int lat);
    lat = -1;
    @(negedge clk);
    bus0.start = st;
    for (int j = 1; j <= 200 && lat < 0; j++) begin
      @(negedge clk);
      bus0.start = 2'b00;
      if (bus0.done === 1'b1) lat = j;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #3;
    total++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      bad++; $display("FAIL reset_status0 busy=%b done=%b want 0 0", bus0.busy, bus0.done);
    end
    total++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      bad++; $display("FAIL reset_status1 busy=%b done=%b want 0 0", bus1.busy, bus1.done);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus0.h_next_flat !== '0) begin
      bad++; $display("FAIL reset_h_next0 got nonzero want 0");
    end
    total++;
    if (bus1.h_next_flat !== '0) begin
      bad++; $display("FAIL reset_h_next1 got nonzero want 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    bit busy_ok;
    logic [15:0] want, got;
    fill0(16'h3c00, 16'h3c00, 16'h4000);
    for (int e = 0; e < E0; e++) exp_q.push_back(16'h4200);
    @(negedge clk); bus0.start = 2'b01;
    @(negedge clk); bus0.start = 2'b00;
    @(negedge clk);
    total++;
    if (bus0.busy !== 1'b0) begin
      bad++; $display("FAIL basic_no_early_go busy=%b want 0", bus0.busy);
    end
    @(negedge clk); bus0.start = 2'b10;
    lat = -1;
    busy_ok = 1'b1;
    for (int j = 1; j <= 200 && lat < 0; j++) begin
      @(negedge clk);
      bus0.start = 2'b00;
      if (bus0.done === 1'b1) begin
        lat = j;
        if (bus0.busy !== 1'b0) busy_ok = 1'b0;
      end else if (bus0.busy !== 1'b1) busy_ok = 1'b0;
    end
    total++;
    if (lat != 23) begin bad++; $display("FAIL basic_latency got=%0d want 23", lat); end
    total++;
    if (!busy_ok) begin bad++; $display("FAIL basic_busy got=0 want 1 throughout run"); end
    @(negedge clk);
    total++;
    if (bus0.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse done=%b want 0", bus0.done); end
    for (int e = 0; e < E0; e++) begin
      want = exp_q.pop_front();
      got  = bus0.h_next_flat[e*DW +: DW];
      total++;
      if (got !== want) begin bad++; $display("FAIL basic_h_next[%0d] got=%h want=%h", e, got, want); end
    end
  endtask

  task automatic test_masked();
    int lat;
    logic [15:0] want, got;
    for (int h = 0; h < 4; h++) bus1.dA_flat[h*DW +: DW] = int_to_fp16(h + 1);
    for (int e = 0; e < E1; e++) begin
      bus1.h_prev_flat[e*DW +: DW] = int_to_fp16(e);
      bus1.dBx_flat[e*DW +: DW]    = 16'h0000;
      exp_q.push_back(int_to_fp16((e / 20 + 1) * e));
    end
    @(negedge clk); bus1.start = 2'b11;
    lat = -1;
    for (int j = 1; j <= 200 && lat < 0; j++) begin
      @(negedge clk);
      bus1.start = 2'b00;
      if (bus1.done === 1'b1) lat = j;
    end
    total++;
    if (lat != 24) begin bad++; $display("FAIL masked_latency got=%0d want 24", lat); end
    for (int e = 0; e < E1; e++) begin
      want = exp_q.pop_front();
      got  = bus1.h_next_flat[e*DW +: DW];
      total++;
      if (got !== want) begin bad++; $display("FAIL masked_h_next[%0d] got=%h want=%h", e, got, want); end
    end
  endtask

  task automatic test_rerun();
    int lat;
    int extra_done, extra_busy;
    logic [15:0] want, got;
    fill0(16'h3c00, 16'h3c00, 16'h3c00);
    for (int e = 0; e < E0; e++) exp_q.push_back(16'h4000);
    @(negedge clk); bus0.start = 2'b11;
    lat = -1;
    for (int j = 1; j <= 200 && lat < 0; j++) begin
      @(negedge clk);
      bus0.start = (j == 5) ? 2'b01 : (j == 10) ? 2'b10 : 2'b00;
      if (bus0.done === 1'b1) begin
        lat = j;
        bus0.start = 2'b11;
      end
    end
    @(negedge clk); bus0.start = 2'b00;
    total++;
    if (lat != 23) begin bad++; $display("FAIL rerun_latency got=%0d want 23", lat); end
    extra_done = 0;
    extra_busy = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus0.done === 1'b1) extra_done++;
      if (bus0.busy === 1'b1) extra_busy++;
    end
    total++;
    if (extra_done != 0 || extra_busy != 0) begin
      bad++; $display("FAIL rerun_ignored_starts done_cycles=%0d busy_cycles=%0d want 0 0",
                      extra_done, extra_busy);
    end
    for (int e = 0; e < E0; e++) begin
      want = exp_q.pop_front();
      got  = bus0.h_next_flat[e*DW +: DW];
      total++;
      if (got !== want) begin bad++; $display("FAIL rerun_h_next[%0d] got=%h want=%h", e, got, want); end
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [15:0] want, got;
    fill0(16'h4000, 16'h4000, 16'h0000);
    @(negedge clk); bus0.start = 2'b11;
    @(negedge clk); bus0.start = 2'b00;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus0.h_next_flat !== '0) begin bad++; $display("FAIL abort_h_next got nonzero want 0"); end
    total++;
    if (bus0.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want 0", bus0.busy); end
    total++;
    if (bus0.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want 0", bus0.done); end
    @(negedge clk); rst = 1'b0;
    for (int e = 0; e < E0; e++) exp_q.push_back(16'h4400);
    go_dut0(2'b11, lat);
    total++;
    if (lat != 23) begin bad++; $display("FAIL abort_rerun_latency got=%0d want 23", lat); end
    for (int e = 0; e < E0; e++) begin
      want = exp_q.pop_front();
      got  = bus0.h_next_flat[e*DW +: DW];
      total++;
      if (got !== want) begin bad++; $display("FAIL abort_h_next[%0d] got=%h want=%h", e, got, want); end
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [15:0] want, got, pinf, ninf;
`ifdef SSM_STATE_SAT_EN
    pinf = 16'h7bff; ninf = 16'hfbff;
`else
    pinf = 16'h7c00; ninf = 16'hfc00;
`endif
    fill0(16'h7bff, 16'h7bff, 16'h0000);
    bus0.dA_flat[3*DW +: DW] = 16'hfbff;
    for (int e = 0; e < E0; e++) begin
      if (e % 2 == 1) begin
        bus0.h_prev_flat[e*DW +: DW] = 16'h7e01;
        exp_q.push_back(16'h7e00);
      end else begin
        exp_q.push_back((e >= 48) ? ninf : pinf);
      end
    end
    go_dut0(2'b11, lat);
    total++;
    if (lat != 23) begin bad++; $display("FAIL overflow_latency got=%0d want 23", lat); end
    for (int e = 0; e < E0; e++) begin
      want = exp_q.pop_front();
      got  = bus0.h_next_flat[e*DW +: DW];
      total++;
      if (fp16_nan(want)) begin
        if (!fp16_nan(got)) begin bad++; $display("FAIL overflow_nan[%0d] got=%h want NaN", e, got); end
      end else if (got !== want) begin
        bad++; $display("FAIL overflow_h_next[%0d] got=%h want=%h", e, got, want);
      end
    end
  endtask

  initial begin
    bus0.start = '0; bus0.dA_flat = '0; bus0.h_prev_flat = '0; bus0.dBx_flat = '0;
    bus1.start = '0; bus1.dA_flat = '0; bus1.h_prev_flat = '0; bus1.dBx_flat = '0;
    test_reset();
    test_basic();
    test_masked();
    test_rerun();
    test_abort();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
